reg_writeback: RTL and testbench
================================

Name: reg_writeback

Overview:
- Write-side initiator for the core register file.
- Collects destination-register results from the ALU and the load/store unit (LSU) and buffers them in a small in-order FIFO.
- Drains the FIFO onto the regfile write port (reg_write_enable / rd_addr / data_write), one write per cycle, only while core_state is in the write phase.
- Also flags writes to read-only registers and answers a pending-write query used by operand fetch for hazard checks.

Parameters:
- DEPTH, 4, FIFO entries; power of two, ≥2.
- DATA_W, 8, register data width.
- ADDR_W, 4, register address width.
- RO_BASE, 13, first read-only register index; writes to rd ≥ RO_BASE are discarded.
- WRITE_STATE, 3'b000, core_state value in which regfile writes are issued.

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous, active-high
- core_state  in  3  core pipeline phase
- alu_valid  in  1  ALU result offered
- alu_ready  out  1  ALU result accepted this cycle
- alu_rd  in  ADDR_W  ALU destination register
- alu_data  in  DATA_W  ALU result
- lsu_valid  in  1  load result offered
- lsu_ready  out  1  load result accepted this cycle
- lsu_rd  in  ADDR_W  load destination register
- lsu_data  in  DATA_W  load data
- reg_write_enable  out  1  regfile write strobe
- rd_addr  out  ADDR_W  regfile write address
- data_write  out  DATA_W  regfile write data
- pend_addr  in  ADDR_W  register queried for an outstanding write
- pend_hit  out  1  combinational; 1 if any queued entry targets pend_addr
- ro_violation  out  1  one-cycle pulse when a read-only write is dropped
- count  out  $clog2(DEPTH)+1  current FIFO occupancy
- busy  out  1  count != 0 or reg_write_enable

Behaviour:
- Reset (synchronous; clk rising edge with reset=1):
  - count=0, head/tail pointers=0.
  - reg_write_enable=0, rd_addr=0, data_write=0, ro_violation=0.
  - Reset overrides any same-cycle push or pop; queued entries are lost.
- Accept / handshake:
  - alu_ready = !full.
  - lsu_ready = !full && !alu_valid, so the ALU has fixed priority.
  - At most one enqueue per cycle. A transfer occurs on valid && ready at the clock edge.
  - Ready does not depend on a same-cycle pop; a full FIFO stalls producers even while draining.
- Read-only filter:
  - An accepted transfer with rd ≥ RO_BASE is handshaken (ready=1) but not enqueued.
  - ro_violation=1 for the following cycle only.
- Drain:
  - If core_state==WRITE_STATE and count>0 on a clock edge, pop the head entry.
  - In the same edge, register reg_write_enable=1, rd_addr=entry rd, data_write=entry data.
  - Otherwise reg_write_enable=0 and rd_addr/data_write hold their last values.
  - Latency: an entry pushed at edge N into an empty FIFO appears on the regfile port after edge N+1 at the earliest, provided core_state==WRITE_STATE at N+1.
  - Leaving WRITE_STATE stops draining immediately; remaining entries persist.
- Ordering: strict FIFO. Two writes to the same rd retire in acceptance order, last value wins.
- Count:
  - Push only → +1; pop only → −1; push and pop in the same cycle → unchanged.
  - Pointers wrap modulo DEPTH.
  - Pop never occurs when empty; push never occurs when full.
- pend_hit:
  - Combinational OR over all valid entries of (entry rd == pend_addr).
  - Excludes the entry already presented on the write port.

Test Plan:
- Reset, then alu_valid=1, alu_rd=2, alu_data=127 for 1 cycle, with core_state=3'b011 → count=1, pend_hit=1 for pend_addr=2, reg_write_enable=0. Then core_state=3'b000 → next cycle reg_write_enable=1, rd_addr=2, data_write=127, count=0.
- alu_valid and lsu_valid both 1 (alu_rd=3/63, lsu_rd=4/9) → alu_ready=1, lsu_ready=0. LSU accepted on the following cycle. Drain order: 3/63, then 4/9.
- Push 4 entries with core_state=3'b011 → count=4, alu_ready=0 and lsu_ready=0. Switch to 3'b000 → 4 consecutive writes in order, count falls to 0, then reg_write_enable=0.
- alu_rd=13, alu_data=5 → alu_ready=1, ro_violation pulses once, count stays 0, no regfile write.
- Interrupt draining: 3 entries queued, core_state=3'b000 for 1 cycle then 3'b011 → exactly 1 write, count=2. Assert reset mid-stream → count=0 and all outputs 0 on the next cycle.
- Simultaneous push and pop at count=2 in WRITE_STATE → count stays 2. The written data equals the oldest entry.

Source files
------------

// File: rtl/reg_writeback.sv
// Register-file writeback initiator: merges ALU and LSU results into an in-order
// FIFO and drains it onto the regfile write port while the core is in its write phase.
module reg_writeback #(
  parameter int          DEPTH       = 4,
  parameter int          DATA_W      = 8,
  parameter int          ADDR_W      = 4,
  parameter int          RO_BASE     = 13,
  parameter logic [2:0]  WRITE_STATE = 3'b000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [2:0]               core_state,
  input  logic                     alu_valid,
  output logic                     alu_ready,
  input  logic [ADDR_W-1:0]        alu_rd,
  input  logic [DATA_W-1:0]        alu_data,
  input  logic                     lsu_valid,
  output logic                     lsu_ready,
  input  logic [ADDR_W-1:0]        lsu_rd,
  input  logic [DATA_W-1:0]        lsu_data,
  output logic                     reg_write_enable,
  output logic [ADDR_W-1:0]        rd_addr,
  output logic [DATA_W-1:0]        data_write,
  input  logic [ADDR_W-1:0]        pend_addr,
  output logic                     pend_hit,
  output logic                     ro_violation,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     busy
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [ADDR_W:0] RO_LIM = (ADDR_W+1)'(RO_BASE);

  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

  wb_entry_t        mem [DEPTH];
  wb_entry_t        in_e;
  logic [PTR_W-1:0] head, tail;
  logic             full, take_alu, take_lsu, accept, ro_hit, push, pop;

  // Ready is a function of occupancy only, so a draining full FIFO still stalls producers.
  assign full      = (count == CNT_W'(DEPTH));
  assign alu_ready = !full;
  assign lsu_ready = !full && !alu_valid;
  assign take_alu  = alu_valid && alu_ready;
  assign take_lsu  = lsu_valid && lsu_ready;
  assign accept    = take_alu || take_lsu;

  always_comb begin
    in_e = take_alu ? wb_entry_t'{alu_rd, alu_data} : wb_entry_t'{lsu_rd, lsu_data};
  end

  assign ro_hit = ({1'b0, in_e.rd} >= RO_LIM);
  assign push   = accept && !ro_hit;
  assign pop    = (core_state == WRITE_STATE) && (count != '0);
  assign busy   = (count != '0) || reg_write_enable;

  always_ff @(posedge clk) begin
    if (push && !reset) mem[tail] <= in_e;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head             <= '0;
      tail             <= '0;
      count            <= '0;
      reg_write_enable <= 1'b0;
      rd_addr          <= '0;
      data_write       <= '0;
      ro_violation     <= 1'b0;
    end else begin
      ro_violation <= accept && ro_hit;
      if (push) tail <= tail + 1'b1;
      if (pop) begin
        head             <= head + 1'b1;
        reg_write_enable <= 1'b1;
        rd_addr          <= mem[head].rd;
        data_write       <= mem[head].data;
      end else begin
        reg_write_enable <= 1'b0;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // A slot is live if its distance from head is below the occupancy; popped entries are gone.
  always_comb begin
    logic [PTR_W-1:0] off;
    pend_hit = 1'b0;
    off      = '0;
    for (int j = 0; j < DEPTH; j++) begin
      off = PTR_W'(j) - head;
      if (({1'b0, off} < count) && (mem[j].rd == pend_addr)) pend_hit = 1'b1;
    end
  end
endmodule

// File: tb/tb_reg_writeback.sv
// Randomized scoreboard bench for reg_writeback against a queue-based reference model.
module tb_reg_writeback;
  localparam int DEPTH = 4;
  localparam int RO_BASE = 13;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] core_state;
  logic       alu_valid, alu_ready, lsu_valid, lsu_ready;
  logic [3:0] alu_rd, lsu_rd, rd_addr, pend_addr;
  logic [7:0] alu_data, lsu_data, data_write;
  logic       reg_write_enable, pend_hit, ro_violation, busy;
  logic [2:0] count;

  reg_writeback #(.DEPTH(DEPTH), .DATA_W(8), .ADDR_W(4), .RO_BASE(RO_BASE),
                  .WRITE_STATE(3'b000)) dut (
    .clk(clk), .reset(reset), .core_state(core_state),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
    .reg_write_enable(reg_write_enable), .rd_addr(rd_addr), .data_write(data_write),
    .pend_addr(pend_addr), .pend_hit(pend_hit), .ro_violation(ro_violation),
    .count(count), .busy(busy));

  always #5 clk = ~clk;

  typedef struct { logic [3:0] rd; logic [7:0] data; } ent_t;
  ent_t mq[$];      // model FIFO contents
  ent_t exp_wr[$];  // writes the DUT must present, in order
  logic exp_ro = 1'b0;
  logic mon_en = 1'b0;
  int   n_chk = 0, n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic model_pend(input logic [3:0] a);
    foreach (mq[i]) if (mq[i].rd == a) return 1'b1;
    return 1'b0;
  endfunction

  // One clock of stimulus; inputs are driven just after a rising edge.
  task automatic step(input logic av, input logic [3:0] ar, input logic [7:0] ad,
                      input logic lv, input logic [3:0] lr, input logic [7:0] ld,
                      input logic [2:0] cs, input logic rst);
    logic full, ta, tl;
    ent_t e;
    alu_valid = av; alu_rd = ar; alu_data = ad;
    lsu_valid = lv; lsu_rd = lr; lsu_data = ld;
    core_state = cs; reset = rst; pend_addr = 4'($urandom_range(0, 15));
    @(negedge clk);
    full = (mq.size() == DEPTH);
    ta = av && !full;
    tl = lv && !full && !av;
    if (mon_en) begin
      chk("alu_ready", alu_ready, !full);
      chk("lsu_ready", lsu_ready, !full && !av);
    end
    @(posedge clk);
    if (rst) begin
      mq.delete();
      exp_wr.delete();
      exp_ro = 1'b0;
    end else begin
      if (cs == 3'b000 && mq.size() > 0) exp_wr.push_back(mq.pop_front());
      exp_ro = 1'b0;
      if (ta || tl) begin
        e.rd = ta ? ar : lr;
        e.data = ta ? ad : ld;
        if (int'(e.rd) >= RO_BASE) exp_ro = 1'b1;
        else mq.push_back(e);
      end
    end
    #1;
  endtask

  task automatic idle(input logic [2:0] cs);
    step(1'b0, 4'd0, 8'd0, 1'b0, 4'd0, 8'd0, cs, 1'b0);
  endtask

  task automatic push_alu(input logic [3:0] r, input logic [7:0] d, input logic [2:0] cs);
    step(1'b1, r, d, 1'b0, 4'd0, 8'd0, cs, 1'b0);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a write.
  initial begin
    ent_t e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        chk("write_present", reg_write_enable, exp_wr.size() > 0);
        if (reg_write_enable && exp_wr.size() > 0) begin
          e = exp_wr.pop_front();
          chk("wr_rd", rd_addr, e.rd);
          chk("wr_data", data_write, e.data);
        end
        chk("ro_violation", ro_violation, exp_ro);
        chk("count", count, mq.size());
        chk("pend_hit", pend_hit, model_pend(pend_addr));
        chk("busy", busy, (mq.size() != 0) || reg_write_enable);
      end
    end
  end

  initial begin
    @(posedge clk); #1;
    step(0, 0, 0, 0, 0, 0, 3'b011, 1'b1);
    step(0, 0, 0, 0, 0, 0, 3'b011, 1'b1);
    mon_en = 1'b1;
    chk("rst_rwe", reg_write_enable, 0);
    chk("rst_rd", rd_addr, 0);
    chk("rst_data", data_write, 0);
    chk("rst_count", count, 0);

    // Single entry, held outside the write phase, then drained.
    push_alu(4'd2, 8'd127, 3'b011);
    pend_addr = 4'd2; #1;
    chk("t1_pend", pend_hit, 1);
    chk("t1_count", count, 1);
    chk("t1_rwe", reg_write_enable, 0);
    idle(3'b000);
    chk("t1_wr", {reg_write_enable, rd_addr, data_write}, {1'b1, 4'd2, 8'd127});
    chk("t1_cnt0", count, 0);

    // ALU priority over LSU.
    step(1, 4'd3, 8'd63, 1, 4'd4, 8'd9, 3'b011, 0);
    step(0, 4'd0, 8'd0, 1, 4'd4, 8'd9, 3'b011, 0);
    idle(3'b000);
    chk("t2_first", {rd_addr, data_write}, {4'd3, 8'd63});
    idle(3'b000);
    chk("t2_second", {rd_addr, data_write}, {4'd4, 8'd9});

    // Fill to capacity, then drain.
    for (int i = 0; i < 4; i++) push_alu(4'(i + 5), 8'(8'h10 + i), 3'b011);
    chk("t3_full_cnt", count, 4);
    chk("t3_alu_rdy", alu_ready, 0);
    chk("t3_lsu_rdy", lsu_ready, 0);
    for (int i = 0; i < 5; i++) idle(3'b000);
    chk("t3_empty_rwe", reg_write_enable, 0);

    // Read-only destination is dropped.
    push_alu(4'd13, 8'd5, 3'b011);
    chk("t4_ro", ro_violation, 1);
    chk("t4_cnt", count, 0);
    idle(3'b000);
    chk("t4_ro_off", ro_violation, 0);
    chk("t4_nowr", reg_write_enable, 0);

    // Interrupted drain, then reset mid-stream.
    for (int i = 0; i < 3; i++) push_alu(4'(i + 1), 8'(8'h20 + i), 3'b011);
    idle(3'b000);
    idle(3'b011);
    chk("t5_cnt", count, 2);
    step(1, 4'd7, 8'd77, 0, 0, 0, 3'b000, 1'b1);
    chk("t5_rst", {count, reg_write_enable, rd_addr, data_write, ro_violation}, 0);

    // Push and pop in the same cycle at count 2.
    push_alu(4'd8, 8'hA1, 3'b011);
    push_alu(4'd9, 8'hA2, 3'b011);
    push_alu(4'd10, 8'hA3, 3'b000);
    chk("t6_cnt", count, 2);
    chk("t6_oldest", {rd_addr, data_write}, {4'd8, 8'hA1});
    for (int i = 0; i < 3; i++) idle(3'b000);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      step(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 8'($urandom),
           1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 8'($urandom),
           ($urandom_range(0, 1) == 1) ? 3'b000 : 3'($urandom_range(1, 7)),
           ($urandom_range(0, 99) == 0));
    end
    for (int i = 0; i < 6; i++) idle(3'b000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
